conv_datapath: RTL and testbench
================================

# conv_datapath

3x3 convolution datapath that consumes the strobes of the convolution controller one stage upstream. It holds a 3-column sample window and a 3x3 coefficient kernel. On each entry into the controller's CONVOLVE state it runs a 3-cycle sequential multiply-accumulate and emits one saturated signed 16-bit result with a single-cycle valid pulse. Its output feeds the result/writeback stage.

## Interface
Parameters: none (fixed 8-bit pixels, 8-bit coefficients, 16-bit result).
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- sample_in  in  24  one pixel column; row r = sample_in[8r+7:8r], unsigned
- sample_shift  in  1  shift window one column and load sample_in
- sample_stream  in  1  controller CONVOLVE/stream indication; informational, no effect on datapath state
- convolve_en  in  1  controller convolve enable; its rising edge starts a computation
- coeff_in  in  24  one kernel column; row r = coeff_in[8r+7:8r], two's-complement
- coeff_ld  in  1  load coeff_in into kernel column coeff_sel
- coeff_sel  in  2  kernel column select 0..2; 3 = ignored
- result  out  16  signed saturated convolution sum
- result_valid  out  1  one-cycle pulse when result updates
- sat  out  1  registered with result; 1 = result was clamped
- busy  out  1  MAC in progress
- overrun  out  1  one-cycle pulse: a start arrived while busy

## Operation
- Window W[c][r], c = 0 (oldest) .. 2 (newest), r = 0..2. On sample_shift: W[0] <= W[1], W[1] <= W[2], W[2] <= sample_in.
- Kernel K[c][r]. On coeff_ld with coeff_sel < 3: K[coeff_sel] <= coeff_in. coeff_sel = 3 leaves the kernel unchanged.
- sample_shift and coeff_ld in the same cycle both take effect.
- Start: convolve_en = 1 while its registered copy conv_q = 0.
- In the start cycle, the full window and kernel are copied into snapshot registers and the accumulator is cleared. The MAC uses only the snapshot, so shifts and coefficient loads during a computation do not affect the result in flight.
- FSM states: IDLE, MAC0, MAC1, MAC2.
  - IDLE -> MAC0 on start.
  - MAC0 -> MAC1 -> MAC2 unconditionally.
  - MAC2 -> IDLE.
  - In any MACn state, a start sets overrun = 1 for one cycle, reloads the snapshot, clears the accumulator and goes to MAC0. The aborted computation produces no result_valid.
- In MACn: acc <= acc + sum over r of (snapshot W[n][r] × snapshot K[n][r]).
- Arithmetic widths:
  - Each pixel is zero-extended to 9-bit signed; each product is 17-bit signed.
  - The accumulator is 20-bit signed. Full range is -293760..+291465, so the accumulator cannot overflow.
- On leaving MAC2, the final sum (acc + column-2 term) is clamped to [-32768, 32767] and registered into result. sat = 1 if the clamp was applied, else 0. result_valid pulses.
- result and sat hold their value until the next completed computation.
- busy = 1 in MAC0, MAC1 and MAC2.

## Timing
- Reset values are 0 for all of the following:
  - result, result_valid, sat, busy, overrun
  - window, kernel, snapshot, acc and conv_q
  - state = IDLE
- Reset mid-operation aborts immediately; no result_valid is produced after reset is released.
- Start detected in cycle T: MAC0 at T+1, MAC1 at T+2, MAC2 at T+3; result, sat and result_valid (high for exactly one cycle) are registered at T+4.
- busy is high T+1..T+3.
- A start in cycle T+1..T+3 sets overrun high in the following cycle; the new computation's result appears 4 cycles after that start.
- A start in cycle T+4 (MAC2 -> IDLE edge already passed) is a normal start: no overrun, and back-to-back results are allowed.
- convolve_en held high produces exactly one computation. A low cycle followed by high is required to start another.
- Samples shifted in the start cycle are not part of that computation. The window register updates on the same edge that the snapshot captures it, so the snapshot holds the pre-shift window.

## Test plan
- Kernel all +1 (three coeff_ld, sel 0..2, coeff_in = 24'h010101); shift three columns of 24'h0A0A0A; pulse convolve_en -> result = 90, sat = 0, result_valid exactly 4 cycles after the start cycle.
- Sobel kernel with col0 = (-1,-2,-1), col1 = 0, col2 = (1,2,1); window col0 = 0, col1 = 0, col2 = 255 -> result = 1020, sat = 0.
- Kernel all 8'h7F, pixels all 8'hFF -> result = 32767, sat = 1. Kernel all 8'h80, pixels all 8'hFF -> result = -32768, sat = 1.
- Start, then a sample_shift and a coeff_ld of zeros in T+1 -> result still uses the snapshot (90 in the first scenario's setup). coeff_sel = 3 load leaves the kernel unchanged.
- Start at T, second start (convolve_en low for one cycle, then high) at T+2 -> overrun pulse at T+3, no valid at T+4, valid at T+6 with the second window's result.
- Assert n_rst low during MAC1 -> all outputs 0, state IDLE, no result_valid after release. A new start then yields a correct result from the reset (all-zero) window: 0.

Source files
------------

// File: rtl/conv_datapath.sv
// 3x3 convolution datapath: 3-column sample window, 3x3 kernel, 3-cycle
// sequential MAC over a start-time snapshot, saturated signed 16-bit result.
module conv_datapath (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [23:0] sample_in,
    input  logic        sample_shift,
    input  logic        sample_stream,
    input  logic        convolve_en,
    input  logic [23:0] coeff_in,
    input  logic        coeff_ld,
    input  logic [1:0]  coeff_sel,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        sat,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, MAC0, MAC1, MAC2} state_t;

    state_t             state_q;
    logic [23:0]        win_q   [3];
    logic [23:0]        ker_q   [3];
    logic [23:0]        win_s_q [3];
    logic [23:0]        ker_s_q [3];
    logic signed [19:0] acc_q;
    logic               conv_q;

    logic               start;
    logic [1:0]         col;
    logic signed [19:0] term;
    logic signed [19:0] acc_d;
    logic [15:0]        res_d;
    logic               sat_d;
    logic               unused_stream;

    assign unused_stream = sample_stream;

    // Pixels are zero-extended to 9-bit signed, so each product fits 17 bits.
    function automatic logic signed [19:0] col_term(input logic [23:0] px,
                                                    input logic [23:0] cf);
        logic signed [8:0]  pix;
        logic signed [7:0]  cof;
        logic signed [16:0] prod;
        logic signed [19:0] s;
        s = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            pix  = {1'b0, px[8*r +: 8]};
            cof  = cf[8*r +: 8];
            prod = 17'(pix) * 17'(cof);
            s    = s + 20'(prod);
        end
        return s;
    endfunction

    always_comb begin
        start = convolve_en & ~conv_q;
        case (state_q)
            MAC0:    col = 2'd0;
            MAC1:    col = 2'd1;
            default: col = 2'd2;
        endcase
        term  = col_term(win_s_q[col], ker_s_q[col]);
        acc_d = acc_q + term;
        sat_d = 1'b0;
        res_d = acc_d[15:0];
        if (acc_d > 20'sd32767) begin
            res_d = 16'h7FFF;
            sat_d = 1'b1;
        end else if (acc_d < -20'sd32768) begin
            res_d = 16'h8000;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            conv_q       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            sat          <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                win_q[i]   <= '0;
                ker_q[i]   <= '0;
                win_s_q[i] <= '0;
                ker_s_q[i] <= '0;
            end
        end else begin
            conv_q       <= convolve_en;
            result_valid <= 1'b0;
            overrun      <= 1'b0;

            if (sample_shift) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= sample_in;
            end
            if (coeff_ld && coeff_sel != 2'd3)
                ker_q[coeff_sel] <= coeff_in;

            // A start always wins: it restarts from a fresh snapshot, and
            // when it lands mid-computation the old result is dropped.
            if (start) begin
                win_s_q <= win_q;
                ker_s_q <= ker_q;
                acc_q   <= '0;
                state_q <= MAC0;
                busy    <= 1'b1;
                overrun <= (state_q != IDLE);
            end else begin
                case (state_q)
                    MAC0: begin
                        acc_q   <= acc_d;
                        state_q <= MAC1;
                    end
                    MAC1: begin
                        acc_q   <= acc_d;
                        state_q <= MAC2;
                    end
                    MAC2: begin
                        acc_q        <= acc_d;
                        result       <= res_d;
                        sat          <= sat_d;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_datapath.sv
// Scoreboard bench for conv_datapath: a behavioural window/kernel model
// pushes expected results at each start; a monitor pops them on result_valid.
module tb_conv_datapath;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [23:0] sample_in = '0;
    logic        sample_shift = 1'b0;
    logic        sample_stream = 1'b0;
    logic        convolve_en = 1'b0;
    logic [23:0] coeff_in = '0;
    logic        coeff_ld = 1'b0;
    logic [1:0]  coeff_sel = '0;
    logic [15:0] result;
    logic        result_valid;
    logic        sat;
    logic        busy;
    logic        overrun;

    conv_datapath dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sample_in    (sample_in),
        .sample_shift (sample_shift),
        .sample_stream(sample_stream),
        .convolve_en  (convolve_en),
        .coeff_in     (coeff_in),
        .coeff_ld     (coeff_ld),
        .coeff_sel    (coeff_sel),
        .result       (result),
        .result_valid (result_valid),
        .sat          (sat),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] mw[3][3];
    logic [7:0] mk[3][3];
    bit         m_conv;
    int         mac_left;
    bit         ovr_pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model_result();
        int   s;
        exp_t e;
        s = 0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                s += int'(mw[c][r]) * int'($signed(mk[c][r]));
        if (s > 32767) begin
            e.res = 16'h7FFF; e.sat = 1'b1;
        end else if (s < -32768) begin
            e.res = 16'h8000; e.sat = 1'b1;
        end else begin
            e.res = s[15:0];  e.sat = 1'b0;
        end
        e.cyc = cyc + 4;
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) begin
                mw[c][r] = '0;
                mk[c][r] = '0;
            end
        m_conv   = 0;
        mac_left = 0;
        ovr_pend = 0;
        sb.delete();
    endtask

    // One clock cycle: drive, check busy/overrun mid-cycle, advance model.
    task automatic cyc1(input bit en, input bit sh, input logic [23:0] sv,
                        input bit ld, input logic [1:0] sel, input logic [23:0] cv);
        convolve_en  = en;
        sample_shift = sh;
        sample_in    = sv;
        coeff_ld     = ld;
        coeff_sel    = sel;
        coeff_in     = cv;
        @(negedge clk);
        chk("busy", busy, mac_left > 0);
        chk("overrun", overrun, ovr_pend);
        ovr_pend = 0;
        if (en && !m_conv) begin
            if (mac_left > 0) begin
                ovr_pend = 1;
                void'(sb.pop_back());
            end
            sb.push_back(model_result());
            mac_left = 3;
        end else if (mac_left > 0) begin
            mac_left--;
        end
        m_conv = en;
        if (sh) begin
            for (int r = 0; r < 3; r++) begin
                mw[0][r] = mw[1][r];
                mw[1][r] = mw[2][r];
                mw[2][r] = sv[8*r +: 8];
            end
        end
        if (ld && sel != 2'd3)
            for (int r = 0; r < 3; r++) mk[sel][r] = cv[8*r +: 8];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1(0, 0, '0, 0, 2'd0, '0);
    endtask

    task automatic load_col(input logic [1:0] sel, input logic [23:0] v);
        cyc1(0, 0, '0, 1, sel, v);
    endtask

    task automatic shift_col(input logic [23:0] v);
        cyc1(0, 1, v, 0, 2'd0, '0);
    endtask

    task automatic start();
        cyc1(1, 0, '0, 0, 2'd0, '0);
        cyc1(0, 0, '0, 0, 2'd0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_result"}, result, 16'h0);
        chk({tag, "_valid"}, result_valid, 1'b0);
        chk({tag, "_sat"}, sat, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_overrun"}, overrun, 1'b0);
    endtask

    always @(negedge clk) begin
        if (n_rst === 1'b1 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_sat", sat, e.sat);
                chk("sb_valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        n_rst = 1'b1;

        // Kernel all +1, window all 10.
        for (int c = 0; c < 3; c++) load_col(2'(c), 24'h010101);
        repeat (3) shift_col(24'h0A0A0A);
        start();
        idle(5);
        chk("ones_result", result, 16'd90);
        chk("ones_sat", sat, 1'b0);

        // Sobel-style kernel against a single bright column.
        load_col(2'd0, 24'hFFFEFF);
        load_col(2'd1, 24'h000000);
        load_col(2'd2, 24'h010201);
        shift_col(24'h000000);
        shift_col(24'h000000);
        shift_col(24'hFFFFFF);
        start();
        idle(5);
        chk("sobel_result", result, 16'd1020);
        chk("sobel_sat", sat, 1'b0);

        // Positive and negative saturation.
        for (int c = 0; c < 3; c++) load_col(2'(c), 24'h7F7F7F);
        repeat (3) shift_col(24'hFFFFFF);
        start();
        idle(5);
        chk("satpos_result", result, 16'h7FFF);
        chk("satpos_sat", sat, 1'b1);
        for (int c = 0; c < 3; c++) load_col(2'(c), 24'h808080);
        start();
        idle(5);
        chk("satneg_result", result, 16'h8000);
        chk("satneg_sat", sat, 1'b1);

        // Shift and coefficient load right after start must not disturb it.
        for (int c = 0; c < 3; c++) load_col(2'(c), 24'h010101);
        repeat (3) shift_col(24'h0A0A0A);
        cyc1(1, 0, '0, 0, 2'd0, '0);
        cyc1(0, 1, 24'h000000, 1, 2'd0, 24'h000000);
        idle(5);
        chk("snapshot_result", result, 16'd90);
        cyc1(0, 0, '0, 1, 2'd3, 24'h000000);
        start();
        idle(5);
        chk("sel3_result", result, 16'd30);

        // Restart at T+2: overrun at T+3, only the second result appears.
        cyc1(1, 0, '0, 0, 2'd0, '0);
        cyc1(0, 1, 24'h141414, 0, 2'd0, '0);
        cyc1(1, 0, '0, 0, 2'd0, '0);
        idle(7);
        chk("overrun_result", result, 16'd60);

        // convolve_en held high gives exactly one computation.
        repeat (6) cyc1(1, 0, '0, 0, 2'd0, '0);
        idle(6);

        // Back-to-back: second start lands at T+4, no overrun.
        cyc1(1, 0, '0, 0, 2'd0, '0);
        idle(3);
        cyc1(1, 0, '0, 0, 2'd0, '0);
        idle(6);

        // Reset during MAC1.
        cyc1(1, 0, '0, 0, 2'd0, '0);
        cyc1(0, 0, '0, 0, 2'd0, '0);
        n_rst = 1'b0;
        #2;
        check_zero_outputs("midreset");
        chk("midreset_state", dut.state_q, 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle(6);
        for (int c = 0; c < 3; c++) load_col(2'(c), 24'h010101);
        start();
        idle(5);
        chk("postreset_result", result, 16'd0);
        chk("postreset_sat", sat, 1'b0);

        idle(2);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
